// File: rtl/uart_wb_pkg.sv
// Shared definitions for the serial-command Wishbone bridge.
// Holds the command/response byte codes and the bridge state encoding.
package uart_wb_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    BUS   = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: turns a serial byte stream into single classic Wishbone
// cycles and streams the status / read data back as bytes.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   rx_data, rx_valid       incoming command bytes (one-cycle strobe each)
//   tx_data, tx_valid,      outgoing response bytes, valid held until
//   tx_ready                tx_valid && tx_ready at a rising edge
//   wbm_*                   Wishbone master port (cyc == stb, sel = F in cycle)
//   busy                    high whenever the bridge is not in IDLE
//   overrun                 one-cycle pulse when an rx byte was dropped
module uart_wb_bridge
  import uart_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        overrun
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 32'd1);

  state_t      state_r;
  logic        cmd_we_r;     // latched command: 1 = write
  logic [1:0]  cnt_r;        // byte index within the current field
  logic [1:0]  rsp_last_r;   // index of the final response byte (0 or 3)
  logic [31:0] adr_r;
  logic [31:0] wdat_r;
  logic [31:0] rsp_r;        // response shift register, next byte on top
  logic [15:0] tmo_r;        // cycles spent with cyc high and no ack
  logic        cyc_r;
  logic        we_r;
  logic [3:0]  sel_r;
  logic        tx_valid_r;
  logic [7:0]  tx_data_r;
  logic        overrun_r;

  // Frame decoder, bus master and response serializer in one FSM
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r    <= IDLE;
      cmd_we_r   <= 1'b0;
      cnt_r      <= 2'd0;
      rsp_last_r <= 2'd0;
      adr_r      <= 32'h0000_0000;
      wdat_r     <= 32'h0000_0000;
      rsp_r      <= 32'h0000_0000;
      tmo_r      <= 16'd0;
      cyc_r      <= 1'b0;
      we_r       <= 1'b0;
      sel_r      <= 4'h0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      overrun_r  <= 1'b0;
    end else begin
      // Bytes arriving while a bus cycle or response is in progress are lost
      overrun_r <= rx_valid && ((state_r == BUS) || (state_r == RESP));

      case (state_r)
        IDLE: begin
          if (rx_valid) begin
            cnt_r <= 2'd0;
            if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
              cmd_we_r <= (rx_data == CMD_WR);
              state_r  <= ADDR;
            end else begin
              rsp_r      <= {RSP_BAD, 24'h00_0000};
              rsp_last_r <= 2'd0;
              state_r    <= RESP;
            end
          end
        end

        ADDR: begin
          if (rx_valid) begin
            adr_r <= {adr_r[23:0], rx_data};
            cnt_r <= cnt_r + 2'd1;  // wraps to 0 on the 4th byte
            if (cnt_r == 2'd3) begin
              tmo_r   <= 16'd0;
              state_r <= cmd_we_r ? WDATA : BUS;
            end
          end
        end

        WDATA: begin
          if (rx_valid) begin
            wdat_r <= {wdat_r[23:0], rx_data};
            cnt_r  <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              tmo_r   <= 16'd0;
              state_r <= BUS;
            end
          end
        end

        BUS: begin
          // First BUS cycle only raises the strobe; ack is honoured after that
          if (!cyc_r) begin
            cyc_r <= 1'b1;
            we_r  <= cmd_we_r;
            sel_r <= 4'hF;
          end else if (wbm_ack_i) begin
            cyc_r   <= 1'b0;
            we_r    <= 1'b0;
            sel_r   <= 4'h0;
            cnt_r   <= 2'd0;
            state_r <= RESP;
            if (cmd_we_r) begin
              rsp_r      <= {RSP_OK, 24'h00_0000};
              rsp_last_r <= 2'd0;
            end else begin
              rsp_r      <= wbm_dat_i;
              rsp_last_r <= 2'd3;
            end
          end else if (tmo_r == TMO_LAST) begin
            cyc_r      <= 1'b0;
            we_r       <= 1'b0;
            sel_r      <= 4'h0;
            cnt_r      <= 2'd0;
            rsp_r      <= {RSP_ERR, 24'h00_0000};
            rsp_last_r <= 2'd0;
            state_r    <= RESP;
          end else begin
            tmo_r <= tmo_r + 16'd1;
          end
        end

        RESP: begin
          if (!tx_valid_r) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= rsp_r[31:24];
          end else if (tx_ready) begin
            if (cnt_r == rsp_last_r) begin
              tx_valid_r <= 1'b0;
              cnt_r      <= 2'd0;
              state_r    <= IDLE;
            end else begin
              // Keep tx_valid high and move straight to the next byte
              tx_data_r <= rsp_r[23:16];
              rsp_r     <= {rsp_r[23:0], 8'h00};
              cnt_r     <= cnt_r + 2'd1;
            end
          end
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = cyc_r;
  assign wbm_we_o  = we_r;
  assign wbm_sel_o = sel_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = wdat_r;
  assign busy      = (state_r != IDLE);
  assign overrun   = overrun_r;

endmodule
